msrv32_wr_en_gen: RTL and testbench
===================================

Name: msrv32_wr_en_gen

Overview:
Write-enable qualifier in the write-back stage of the msrv32 pipeline. It gates the decoder's registered integer-register-file and CSR-file write enables with the pipeline flush, so a flushed instruction never commits architectural state. The combinational gated enables drive the register file and CSR file. Registered copies and a sticky suppression flag are provided for forwarding and debug.

Parameters:
CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
ms_riscv32_mp_clk_in  input  1  clock; all state updates on the rising edge.
ms_riscv32_mp_rst_in  input  1  reset; synchronous, active-high.
flush_in  input  1  pipeline flush for the instruction currently in write-back.
rf_wr_en_reg_in  input  1  registered integer register-file write request.
csr_wr_en_reg_in  input  1  registered CSR-file write request.
wr_en_integer_file_out  output  1  qualified integer register-file write enable (combinational).
wr_en_csr_file_out  output  1  qualified CSR-file write enable (combinational).
wr_en_integer_file_q_out  output  1  wr_en_integer_file_out delayed by one cycle.
wr_en_csr_file_q_out  output  1  wr_en_csr_file_out delayed by one cycle.
wr_suppressed_sticky_out  output  1  set when any write request was killed by flush; cleared only by reset.

Behaviour:
- Combinational path, zero latency, independent of clock and reset:
  - wr_en_integer_file_out = rf_wr_en_reg_in AND NOT flush_in.
  - wr_en_csr_file_out = csr_wr_en_reg_in AND NOT flush_in.
- Flush has absolute priority. With flush_in=1 both outputs are 0 regardless of requests.
- The two enables are independent; both may be 1 in the same cycle (e.g. CSRRW with rd≠x0).
- Registered copies: on each rising edge, wr_en_*_q_out <= the corresponding combinational output. Latency is 1 cycle.
- Sticky flag: on each rising edge, set to 1 if flush_in AND (rf_wr_en_reg_in OR csr_wr_en_reg_in). It otherwise holds.
- Reset (synchronous, active-high, rising edge): wr_en_integer_file_q_out=0, wr_en_csr_file_q_out=0, wr_suppressed_sticky_out=0.
- Reset does not gate the combinational outputs; they still follow the inputs while reset is asserted.
- Reset and a suppression event in the same edge: reset wins, so the flag reads 0.
- X on flush_in with both requests 0 must still yield outputs of 0. This holds naturally from the AND gating.

Optional Feature:
Macro MSRV32_WR_EN_STATS_EN.
- When defined, the block adds four CNT_W-bit outputs:
  - rf_commit_cnt_out: count of cycles with wr_en_integer_file_out=1.
  - csr_commit_cnt_out: count of cycles with wr_en_csr_file_out=1.
  - rf_flush_cnt_out: count of cycles with rf_wr_en_reg_in AND flush_in.
  - csr_flush_cnt_out: count of cycles with csr_wr_en_reg_in AND flush_in.
- Counters increment on the rising edge, wrap modulo 2^CNT_W, and clear to 0 on synchronous reset.
- When the macro is not defined, these ports and registers do not exist, and all other behaviour is identical.

Decomposition:
- Shared package msrv32_pkg holds the localparam for the default counter width (MSRV32_STAT_CNT_W=32).
- The package also holds a typedef wr_en_t, a struct of {rf, csr} bits, used for the combinational pair.
- One natural sub-module: msrv32_wr_en_stat_ctr. It is a single CNT_W-bit enable counter with synchronous reset, instantiated four times under the macro.
- No other hierarchy.

Test Plan:
- Walk all 8 combinations of (flush, rf, csr) with 15 ns holds. Check outputs match the truth table: flush=0,rf=1,csr=1 -> 1,1; flush=1,rf=1,csr=1 -> 0,0; flush=0,rf=0,csr=1 -> 0,1; flush=0,rf=1,csr=0 -> 1,0; flush=1,rf=1,csr=0 -> 0,0.
- Reset: assert rst for 2 cycles with rf=1, flush=0. Combinational out=1 throughout; q outputs and sticky are 0 after the reset edge. One cycle after deassertion, wr_en_integer_file_q_out=1.
- Registered latency: toggle rf each cycle with flush=0. wr_en_integer_file_q_out equals the previous cycle's combinational value.
- Sticky: one cycle with flush=1, csr=1. The flag is 1 after that edge and stays 1 through 10 idle cycles. Reset clears it. Reset coinciding with flush=1, csr=1 leaves it 0.
- Stats (macro defined, CNT_W=4): 17 cycles of rf=1, flush=0 gives rf_commit_cnt_out=1 (wrap). 3 cycles of rf=1, csr=1, flush=1 give rf_flush_cnt_out=3 and csr_flush_cnt_out=3, with both commit counters unchanged.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 write-enable qualifier.
// Holds the default statistics counter width and the rf/csr enable pair type.
package msrv32_pkg;

  localparam int MSRV32_STAT_CNT_W = 32;

  // Combinational pair of write enables travelling together.
  typedef struct packed {
    logic rf;
    logic csr;
  } wr_en_t;

  // Kill both requests when the instruction in write-back is flushed.
  // Pure AND gating, so an unknown flush with no requests still gives 0.
  function automatic wr_en_t gate_wr_en(input logic flush,
                                        input logic rf_req,
                                        input logic csr_req);
    wr_en_t res;
    res.rf  = rf_req & ~flush;
    res.csr = csr_req & ~flush;
    return res;
  endfunction

endpackage

// File: rtl/msrv32_wr_en_stat_ctr.sv
// Single enable counter with synchronous active-high reset.
// Wraps modulo 2^CNT_W; used for the write-back statistics.
module msrv32_wr_en_stat_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count enabled cycles; reset clears, natural overflow wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/msrv32_wr_en_gen.sv
// Write-back write-enable qualifier for the msrv32 pipeline.
// Gates the registered rf/csr write requests with flush, so a flushed
// instruction never commits. Also keeps one-cycle delayed copies of the
// gated enables and a sticky "a write was suppressed" flag.
// Optional statistics counters are built when MSRV32_WR_EN_STATS_EN is defined.
module msrv32_wr_en_gen
  import msrv32_pkg::*;
#(
  parameter int CNT_W = MSRV32_STAT_CNT_W
)
(
  input  logic ms_riscv32_mp_clk_in,
  input  logic ms_riscv32_mp_rst_in,
  input  logic flush_in,
  input  logic rf_wr_en_reg_in,
  input  logic csr_wr_en_reg_in,
  output logic wr_en_integer_file_out,
  output logic wr_en_csr_file_out,
  output logic wr_en_integer_file_q_out,
  output logic wr_en_csr_file_q_out,
`ifdef MSRV32_WR_EN_STATS_EN
  output logic [CNT_W-1:0] rf_commit_cnt_out,
  output logic [CNT_W-1:0] csr_commit_cnt_out,
  output logic [CNT_W-1:0] rf_flush_cnt_out,
  output logic [CNT_W-1:0] csr_flush_cnt_out,
`endif
  output logic wr_suppressed_sticky_out
);

  wr_en_t wr_en;
  logic   suppress_evt;

  // Gated enables: zero latency, unaffected by clock or reset.
  always_comb begin
    wr_en        = gate_wr_en(flush_in, rf_wr_en_reg_in, csr_wr_en_reg_in);
    suppress_evt = flush_in & (rf_wr_en_reg_in | csr_wr_en_reg_in);
  end

  assign wr_en_integer_file_out = wr_en.rf;
  assign wr_en_csr_file_out     = wr_en.csr;

  // Delayed enables and sticky suppression flag; reset wins over a same-edge event.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_en_integer_file_q_out <= 1'b0;
      wr_en_csr_file_q_out     <= 1'b0;
      wr_suppressed_sticky_out <= 1'b0;
    end else begin
      wr_en_integer_file_q_out <= wr_en.rf;
      wr_en_csr_file_q_out     <= wr_en.csr;
      if (suppress_evt) begin
        wr_suppressed_sticky_out <= 1'b1;
      end
    end
  end

`ifdef MSRV32_WR_EN_STATS_EN
  msrv32_wr_en_stat_ctr #(.CNT_W(CNT_W)) u_rf_commit_ctr (
    .clk (ms_riscv32_mp_clk_in),
    .rst (ms_riscv32_mp_rst_in),
    .en  (wr_en.rf),
    .cnt (rf_commit_cnt_out)
  );

  msrv32_wr_en_stat_ctr #(.CNT_W(CNT_W)) u_csr_commit_ctr (
    .clk (ms_riscv32_mp_clk_in),
    .rst (ms_riscv32_mp_rst_in),
    .en  (wr_en.csr),
    .cnt (csr_commit_cnt_out)
  );

  msrv32_wr_en_stat_ctr #(.CNT_W(CNT_W)) u_rf_flush_ctr (
    .clk (ms_riscv32_mp_clk_in),
    .rst (ms_riscv32_mp_rst_in),
    .en  (rf_wr_en_reg_in & flush_in),
    .cnt (rf_flush_cnt_out)
  );

  msrv32_wr_en_stat_ctr #(.CNT_W(CNT_W)) u_csr_flush_ctr (
    .clk (ms_riscv32_mp_clk_in),
    .rst (ms_riscv32_mp_rst_in),
    .en  (csr_wr_en_reg_in & flush_in),
    .cnt (csr_flush_cnt_out)
  );
`endif

endmodule

// File: tb/tb_msrv32_wr_en_gen.sv
// Directed bench for msrv32_wr_en_gen. Inputs change on the falling edge,
// registered outputs are checked on a later falling edge.
// Statistics checks are compiled when MSRV32_WR_EN_STATS_EN is defined.
module tb_msrv32_wr_en_gen;

  logic clk;
  logic rst;
  logic flush;
  logic rf;
  logic csr;
  logic wr_int;
  logic wr_csr;
  logic wr_int_q;
  logic wr_csr_q;
  logic sticky;
`ifdef MSRV32_WR_EN_STATS_EN
  logic [3:0] rf_commit_cnt;
  logic [3:0] csr_commit_cnt;
  logic [3:0] rf_flush_cnt;
  logic [3:0] csr_flush_cnt;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] exp_q[$];

  msrv32_wr_en_gen #(.CNT_W(4)) dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_in     (rst),
    .flush_in                 (flush),
    .rf_wr_en_reg_in          (rf),
    .csr_wr_en_reg_in         (csr),
    .wr_en_integer_file_out   (wr_int),
    .wr_en_csr_file_out       (wr_csr),
    .wr_en_integer_file_q_out (wr_int_q),
    .wr_en_csr_file_q_out     (wr_csr_q),
`ifdef MSRV32_WR_EN_STATS_EN
    .rf_commit_cnt_out        (rf_commit_cnt),
    .csr_commit_cnt_out       (csr_commit_cnt),
    .rf_flush_cnt_out         (rf_flush_cnt),
    .csr_flush_cnt_out        (csr_flush_cnt),
`endif
    .wr_suppressed_sticky_out (sticky)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic rq, input logic cq);
    rst   = r;
    flush = f;
    rf    = rq;
    csr   = cq;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Hold one input combination for 15 ns, then check the gated pair.
  task automatic walk(input logic f, input logic rq, input logic cq,
                      input logic exp_rf, input logic exp_csr, input string tag);
    flush = f;
    rf    = rq;
    csr   = cq;
    #15;
    chk({tag, "_rf"}, {31'd0, wr_int}, {31'd0, exp_rf});
    chk({tag, "_csr"}, {31'd0, wr_csr}, {31'd0, exp_csr});
  endtask

  initial begin
    logic [5:0] pat;
    pat = 6'b110101;

    // ---- reset: rf requested, no flush; gating ignores reset ----
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst_comb_pre_edge", {31'd0, wr_int}, 32'd1);
    next_cycle();
    chk("rst_comb_c1", {31'd0, wr_int}, 32'd1);
    chk("rst_int_q", {31'd0, wr_int_q}, 32'd0);
    chk("rst_csr_q", {31'd0, wr_csr_q}, 32'd0);
    chk("rst_sticky", {31'd0, sticky}, 32'd0);
    next_cycle();
    chk("rst_comb_c2", {31'd0, wr_int}, 32'd1);
    chk("rst_int_q_c2", {31'd0, wr_int_q}, 32'd0);
    rst = 1'b0;
    next_cycle();
    chk("post_rst_int_q", {31'd0, wr_int_q}, 32'd1);
    chk("post_rst_csr_q", {31'd0, wr_csr_q}, 32'd0);

    // ---- truth table walk, offset 2 ns so changes avoid clock edges ----
    #2;
    walk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tt_000");
    walk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "tt_001");
    walk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "tt_010");
    walk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "tt_011");
    walk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "tt_100");
    walk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "tt_101");
    walk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "tt_110");
    walk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "tt_111");
    // Unknown flush with no requests must still give zeros.
    walk(1'bx, 1'b0, 1'b0, 1'b0, 1'b0, "tt_x00");

    // ---- registered latency: toggle rf with flush low ----
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      rf = pat[i];
      exp_q.push_back({31'd0, pat[i]});
      next_cycle();
      chk("lat_int_q", {31'd0, wr_int_q}, exp_q.pop_front());
      chk("lat_csr_q", {31'd0, wr_csr_q}, 32'd0);
    end

    // ---- sticky flag ----
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk("sticky_cleared", {31'd0, sticky}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    chk("sticky_set", {31'd0, sticky}, 32'd1);
    chk("sticky_csr_q_killed", {31'd0, wr_csr_q}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      chk("sticky_hold", {31'd0, sticky}, 32'd1);
    end
    rst = 1'b1;
    next_cycle();
    chk("sticky_rst_clear", {31'd0, sticky}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    next_cycle();
    chk("sticky_rst_wins", {31'd0, sticky}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk("sticky_after_rst", {31'd0, sticky}, 32'd0);

`ifdef MSRV32_WR_EN_STATS_EN
    // ---- statistics with 4-bit counters ----
    rst = 1'b1;
    next_cycle();
    chk("cnt_rst_rf_commit", {28'd0, rf_commit_cnt}, 32'd0);
    chk("cnt_rst_rf_flush", {28'd0, rf_flush_cnt}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) next_cycle();
    chk("cnt_rf_commit_wrap", {28'd0, rf_commit_cnt}, 32'd1);
    chk("cnt_csr_commit_idle", {28'd0, csr_commit_cnt}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) next_cycle();
    chk("cnt_rf_flush", {28'd0, rf_flush_cnt}, 32'd3);
    chk("cnt_csr_flush", {28'd0, csr_flush_cnt}, 32'd3);
    chk("cnt_rf_commit_hold", {28'd0, rf_commit_cnt}, 32'd1);
    chk("cnt_csr_commit_hold", {28'd0, csr_commit_cnt}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
